// File: rtl/viterbi_decoder_pkg.sv
// viterbi_decoder_pkg: shared sizes, FSM encoding and flat-bus helpers for the Viterbi decoder
package viterbi_decoder_pkg;
    localparam int N  = 8;
    localparam int I  = 3;
    localparam int K  = 3;
    localparam int W  = 16;
    localparam int SW = W + 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FORWARD  = 2'd1,
        BACKWARD = 2'd2,
        DONE     = 2'd3
    } state_t;

    function automatic int idx3(input int r, input int c);
        return r * 3 + c;
    endfunction

    // Symbol 3 has no table entry and maps to the most negative log-probability
    function automatic logic signed [W-1:0] emit(input logic [9*W-1:0] b, input int j, input logic [1:0] o);
        return (o == 2'd3) ? {1'b1, {(W-1){1'b0}}} : b[idx3(j, int'(o))*W +: W];
    endfunction

    function automatic logic [1:0] argmax3(input logic signed [SW-1:0] a, input logic signed [SW-1:0] b,
                                           input logic signed [SW-1:0] c);
        logic [1:0] m;
        logic signed [SW-1:0] v;
        m = 2'd0;
        v = a;
        if (b > v) begin
            m = 2'd1;
            v = b;
        end
        if (c > v) m = 2'd2;
        return m;
    endfunction
endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs: add-compare-select for one destination state
module viterbi_acs
    import viterbi_decoder_pkg::*;
(
    input  logic signed [SW-1:0] d0,
    input  logic signed [SW-1:0] d1,
    input  logic signed [SW-1:0] d2,
    input  logic signed [W-1:0]  a0,
    input  logic signed [W-1:0]  a1,
    input  logic signed [W-1:0]  a2,
    input  logic signed [W-1:0]  b,
    output logic signed [SW-1:0] nd,
    output logic [1:0]           bp
);
    logic signed [SW-1:0] s0, s1, s2;
    always_comb begin
        s0 = d0 + SW'(a0);
        s1 = d1 + SW'(a1);
        s2 = d2 + SW'(a2);
        bp = argmax3(s0, s1, s2);
        nd = (bp == 2'd0 ? s0 : bp == 2'd1 ? s1 : s2) + SW'(b);
    end
endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: 3-state HMM max-sum forward recursion with backpointer backtrack
module viterbi_decoder
    import viterbi_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       length,
    input  logic [1:0]       obs_in,
    input  logic             obs_valid,
    input  logic [9*W-1:0]   logA_flat,
    input  logic [3*W-1:0]   logC_flat,
    input  logic [9*W-1:0]   logB_flat,
    output logic [2*N-1:0]   path_flat,
    output logic             done
);
    state_t state;
    logic [2:0] len, t, back_t, len_in;
    logic [1:0] cur, prev;
    logic signed [SW-1:0] delta [3];
    logic signed [SW-1:0] fwd [3];
    logic signed [SW-1:0] init [3];
    logic signed [W-1:0]  em [3];
    logic signed [W-1:0]  cv [3];
    logic [1:0] bpn [3];
    logic [1:0] bp [N][3];

    assign len_in = (length == 3'd0) ? 3'd1 : length;
    assign prev   = bp[back_t][cur];

    for (genvar j = 0; j < 3; j++) begin : g_acs
        assign em[j]   = emit(logB_flat, j, obs_in);
        assign cv[j]   = logC_flat[j*W +: W];
        assign init[j] = SW'(cv[j]) + SW'(em[j]);
        viterbi_acs u_acs (
            .d0(delta[0]),
            .d1(delta[1]),
            .d2(delta[2]),
            .a0(logA_flat[idx3(0, j)*W +: W]),
            .a1(logA_flat[idx3(1, j)*W +: W]),
            .a2(logA_flat[idx3(2, j)*W +: W]),
            .b(em[j]),
            .nd(fwd[j]),
            .bp(bpn[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_n && !start && state == FORWARD && obs_valid)
            for (int k = 0; k < 3; k++) bp[t + 3'd1][k] <= bpn[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            path_flat <= '0;
            back_t    <= '0;
            cur       <= '0;
            t         <= '0;
            len       <= 3'd1;
            for (int k = 0; k < 3; k++) delta[k] <= '0;
        end else if (start) begin
            delta     <= init;
            t         <= '0;
            path_flat <= '0;
            done      <= 1'b0;
            len       <= len_in;
            if (len_in == 3'd1) begin
                state  <= BACKWARD;
                back_t <= '0;
                cur    <= argmax3(init[0], init[1], init[2]);
            end else begin
                state  <= FORWARD;
            end
        end else if (state == FORWARD && obs_valid) begin
            delta <= fwd;
            t     <= t + 3'd1;
            if (t + 3'd1 == len - 3'd1) begin
                state  <= BACKWARD;
                back_t <= len - 3'd1;
                cur    <= argmax3(fwd[0], fwd[1], fwd[2]);
            end
        end else if (state == BACKWARD) begin
            path_flat[{back_t, 1'b0} +: 2] <= cur;
            if (back_t == 3'd0) begin
                state <= DONE;
                done  <= 1'b1;
            end else begin
                back_t <= back_t - 3'd1;
                cur    <= prev;
            end
        end
    end
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: directed vectors with hand-computed paths and latencies
module tb_viterbi_decoder;
    import viterbi_decoder_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     length = 3'd0;
    logic [1:0]     obs_in = 2'd0;
    logic           obs_valid = 1'b0;
    logic [9*W-1:0] logA_flat = '0;
    logic [3*W-1:0] logC_flat = '0;
    logic [9*W-1:0] logB_flat = '0;
    logic [2*N-1:0] path_flat;
    logic           done;
    int             n_chk = 0;
    int             n_fail = 0;
    int             cyc;

    viterbi_decoder dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .length(length),
        .obs_in(obs_in),
        .obs_valid(obs_valid),
        .logA_flat(logA_flat),
        .logC_flat(logC_flat),
        .logB_flat(logB_flat),
        .path_flat(path_flat),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] l, input logic [1:0] o);
        start = 1'b1;
        length = l;
        obs_in = o;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] o);
        obs_valid = 1'b1;
        obs_in = o;
        step();
        obs_valid = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 20) begin
            step();
            c++;
        end
    endtask

    task automatic set_all(input int a, input int c, input int bdiag, input int boff);
        for (int i = 0; i < 3; i++) begin
            logC_flat[i*W +: W] = W'(c);
            for (int j = 0; j < 3; j++) begin
                logA_flat[(i*3+j)*W +: W] = W'(a);
                logB_flat[(i*3+j)*W +: W] = W'(i == j ? bdiag : boff);
            end
        end
    endtask

    initial begin
        step();
        step();
        chk("reset_state", 32'(dut.state), 32'(IDLE));
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_path", 32'(path_flat), 32'd0);
        rst_n = 1'b1;

        set_all(-20, -20, 0, -1000);
        do_start(3'd3, 2'd1);
        chk("t1_fwd_state", 32'(dut.state), 32'(FORWARD));
        chk("t1_done_low", 32'(done), 32'd0);
        step();
        send(2'd1);
        step();
        step();
        send(2'd0);
        chk("t1_bwd_state", 32'(dut.state), 32'(BACKWARD));
        wait_done(cyc);
        chk("t1_latency", 32'(cyc), 32'd3);
        chk("t1_path", 32'(path_flat), 32'h0005);
        send(2'd2);
        step();
        chk("t1_done_hold", 32'(done), 32'd1);
        chk("t1_path_hold", 32'(path_flat), 32'h0005);
        chk("t1_state_done", 32'(dut.state), 32'(DONE));

        do_start(3'd3, 2'd0);
        chk("t2_path_clr", 32'(path_flat), 32'd0);
        chk("t2_done_clr", 32'(done), 32'd0);
        send(2'd1);
        send(2'd2);
        wait_done(cyc);
        chk("t2_latency", 32'(cyc), 32'd3);
        chk("t2_path", 32'(path_flat), 32'h0024);

        set_all(-20, -20, 0, 0);
        do_start(3'd4, 2'd0);
        send(2'd1);
        send(2'd2);
        send(2'd0);
        wait_done(cyc);
        chk("t3_latency", 32'(cyc), 32'd4);
        chk("t3_path_ties", 32'(path_flat), 32'h0000);

        set_all(-20, -20, 0, -1000);
        do_start(3'd1, 2'd2);
        chk("t4_bwd_direct", 32'(dut.state), 32'(BACKWARD));
        chk("t4_done_low", 32'(done), 32'd0);
        step();
        chk("t4_done_1cyc", 32'(done), 32'd1);
        chk("t4_path", 32'(path_flat), 32'h0002);

        do_start(3'd0, 2'd1);
        chk("t4b_len0_state", 32'(dut.state), 32'(BACKWARD));
        step();
        chk("t4b_len0_done", 32'(done), 32'd1);
        chk("t4b_len0_path", 32'(path_flat), 32'h0001);

        set_all(-1000, -1000, 0, 0);
        logA_flat[(0*3+1)*W +: W] = 16'sd0;
        logA_flat[(1*3+2)*W +: W] = 16'sd0;
        logC_flat[0 +: W] = 16'sd0;
        do_start(3'd3, 2'd0);
        send(2'd0);
        send(2'd0);
        wait_done(cyc);
        chk("t5_latency", 32'(cyc), 32'd3);
        chk("t5_path", 32'(path_flat), 32'h0024);

        set_all(-20, -20, 0, -1000);
        do_start(3'd2, 2'd3);
        send(2'd1);
        wait_done(cyc);
        chk("t6_invalid_latency", 32'(cyc), 32'd2);
        chk("t6_invalid_path", 32'(path_flat), 32'h0004);

        do_start(3'd3, 2'd1);
        send(2'd1);
        rst_n = 1'b0;
        step();
        chk("t7_rst_state", 32'(dut.state), 32'(IDLE));
        chk("t7_rst_done", 32'(done), 32'd0);
        chk("t7_rst_path", 32'(path_flat), 32'd0);
        rst_n = 1'b1;
        do_start(3'd3, 2'd2);
        send(2'd2);
        send(2'd1);
        wait_done(cyc);
        chk("t7_fresh_latency", 32'(cyc), 32'd3);
        chk("t7_fresh_path", 32'(path_flat), 32'h001A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hardware Viterbi decoder for a small hidden Markov model (3 states, 3 observation symbols). It accepts a streamed observation sequence of up to 7 symbols and log-domain model parameters on flat input buses. It performs forward max-sum recursion with per-step backpointers, then backtracks to produce the most likely state path. It sits as a standalone accelerator; parameters are static while a decode runs.

## Interface
- N, 8: number of path slots in path_flat (max supported length).
- I, 3: number of hidden states (fixed; 2-bit state index).
- K, 3: number of observation symbols (fixed; 2-bit symbol).
- W, 16: signed width of each log-probability term.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  begin decode; obs_in sampled as observation 0 on this edge.
- length  in  3  sequence length in symbols, sampled with start; 0 treated as 1.
- obs_in  in  2  observation symbol.
- obs_valid  in  1  obs_in holds the next observation (t ≥ 1).
- logA_flat  in  9*W  transitions; slice (i*3+j)*W +: W = log P(next=j | prev=i), signed.
- logC_flat  in  3*W  initial log-probabilities; slice j*W +: W.
- logB_flat  in  9*W  emissions; slice (j*3+o)*W +: W = log P(obs=o | state=j).
- path_flat  out  2*N  decoded path; path[t] at bits 2t+1:2t.
- done  out  1  decode complete; held high until next start or reset.

## Operation
- FSM states (2-bit register named state): IDLE=0, FORWARD=1, BACKWARD=2, DONE=3.
- Scores: signed accumulator width W+5 (no overflow for 8 steps); inputs sign-extended; no saturation.
- start (any state, restarts an in-flight decode): delta[j] = C[j] + B[j][obs_in]; t=0; path_flat cleared; done=0. If length ≤ 1, go to BACKWARD; else go to FORWARD.
- FORWARD, obs_valid=1: for each j, best_i = argmax_i(delta[i] + A[i][j]); delta[j] ← max + B[j][obs_in]; bp[t+1][j] ← best_i; t++. When t reaches length-1, go to BACKWARD. obs_valid=0 holds state.
- Ties: lowest state index wins (replacement only on strictly greater). Same rule for final argmax.
- obs_in = 3 (invalid symbol): emission term is -2^(W-1).
- On BACKWARD entry: back_t ← length-1; current_state ← argmax_j delta[j].
- BACKWARD cycle: path[back_t] ← current_state; prev_state = bp[back_t][current_state] (combinational). If back_t=0, go to DONE and set done=1; else back_t--, current_state ← prev_state.
- DONE: outputs stable; obs_valid ignored; only start or reset leaves.
- obs_valid outside FORWARD is ignored. Path slots ≥ length read 0.

## Timing
- Reset: state=IDLE, done=0, path_flat=0, back_t=0, current_state=0, deltas=0. Reset mid-decode aborts immediately.
- Forward: one observation per cycle, one cycle per step; obs_valid may be back-to-back or gapped.
- Backtrack: exactly length cycles after BACKWARD entry; done rises on the edge writing path[0].
- Latency: done high length cycles after the edge accepting the final observation (length 1: 1 cycle after start).
- Parameters must be stable from start to done.

## Structure
- Shared package: state encoding constants, I/K/N/W defaults, index helpers for flat-bus slicing.
- Natural sub-module: viterbi_acs (add-compare-select for one destination state: three deltas plus three A terms plus B → new delta and 2-bit backpointer), instantiated 3×. Backpointer store: N×3×2-bit register array.

## Test plan
- A all -20, C all -20, B diagonal 0 / off-diagonal -1000; length 3; obs 1,1,0 (obs_valid gapped) -> path_flat=0x0005, done stays high.
- Same params; obs 0,1,2 back-to-back -> path_flat=0x0024; done exactly 3 cycles after last obs accepted.
- All B = 0, A and C all equal; length 4 -> ties resolve to state 0 -> path_flat=0x0000.
- length 1, obs 2, diagonal B -> BACKWARD directly after start; done 1 cycle later; path_flat=0x0002.
- A strongly favoring 0→1→2 (others -1000), B all 0, C favoring state 0, length 3 -> path_flat=0x0024.
- rst_n low during FORWARD -> next cycle state=IDLE, done=0, path_flat=0; a fresh decode afterwards gives the correct result.
